// File: rtl/mseq_lfsr_gen_pkg.sv
// Shared constants, seed fold and FSM state type for the M-sequence generators.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package mseq_pkg;

    localparam int          SEED_W         = 288;
    localparam int          LFSR_W         = 32;
    // Feedback taps of x^32+x^22+x^2+x+1 as bit positions 31, 21, 1, 0 of the state.
    localparam logic [31:0] MSEQ_POLY_TAPS = 32'h8020_0003;
    localparam int          MSEQ_NUM       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } mseq_state_t;

    // XOR of the nine 32-bit chunks of the chaotic seed.
    function automatic logic [LFSR_W-1:0] fold_seed(input logic [SEED_W-1:0] seed);
        logic [LFSR_W-1:0] f;
        f = '0;
        for (int k = 0; k < SEED_W / LFSR_W; k++) begin
            f ^= seed[LFSR_W*k +: LFSR_W];
        end
        return f;
    endfunction

endpackage

// File: rtl/mseq_lfsr_gen_if.sv
// Valid/ready stream carrying PRBS words from a generator to its consumer.
// Latency: none (wires only).
// Backpressure: consumer holds dout_ready low; the master keeps dout stable meanwhile.
interface mseq_lfsr_gen_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/mseq_lfsr_gen_core.sv
// Combinational N-step advance of the 32-bit Fibonacci LFSR, collecting the output bits.
// Latency: 0 cycles (pure combinational unroll).
// Backpressure: none; the caller decides whether to register the result.
module mseq_lfsr_core
    import mseq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [LFSR_W-1:0] state_in,
    output logic [LFSR_W-1:0] state_out,
    output logic [N-1:0]      word
);

    logic [LFSR_W-1:0] s;

    // Step N times; the first bit shifted out lands in the word MSB.
    always_comb begin
        s    = state_in;
        word = '0;
        for (int i = 0; i < N; i++) begin
            word[N-1-i] = s[LFSR_W-1];
            s           = {s[LFSR_W-2:0], ^(s & MSEQ_POLY_TAPS)};
        end
        state_out = s;
    end

endmodule

// File: rtl/mseq_lfsr_gen.sv
// Seeded PRBS generator: folds a 288-bit seed into a 32-bit LFSR and streams OUT_W-bit words.
// Latency: strobe at edge T -> first word valid after edge T+2; then 1 word/cycle.
// Backpressure: word and LFSR hold while dout_valid && !dout_ready. Option macro: MSEQ_STATS_EN.
module mseq_lfsr_gen #(
    parameter int          SEED_W   = 288,
    parameter int          MSEQ_IDX = 0,
    parameter int          OUT_W    = 8,
    parameter logic [31:0] ZERO_SUB = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEED_W-1:0] mseq_din,
    input  logic [3:0]        mseq_din_valid,
    mseq_lfsr_gen_if.master   out_if,
    output logic              seeded,
    output logic [15:0]       reseed_cnt
`ifdef MSEQ_STATS_EN
    ,
    output logic [31:0]       word_cnt
`endif
);

    mseq_pkg::mseq_state_t state_q, state_d;

    logic             load;
    logic             gen;
    logic             accept;
    logic [31:0]      fold_raw;
    logic [31:0]      fold_val;
    logic [31:0]      lfsr_q;
    logic [31:0]      lfsr_adv;
    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] dout_q;
    logic             dout_valid_q;

    // Strobes meant for the sibling generators are deliberately not looked at.
    logic unused_strobes;
    assign unused_strobes = ^mseq_din_valid;

    assign load     = mseq_din_valid[MSEQ_IDX];
    assign accept   = dout_valid_q && out_if.dout_ready;
    assign fold_raw = mseq_pkg::fold_seed(mseq_din);
    // An all-zero LFSR would lock up, so a zero fold is replaced.
    assign fold_val = (fold_raw == '0) ? ZERO_SUB : fold_raw;

    assign out_if.dout       = dout_q;
    assign out_if.dout_valid = dout_valid_q;

    mseq_lfsr_core #(.N(OUT_W)) u_core (
        .state_in  (lfsr_q),
        .state_out (lfsr_adv),
        .word      (word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= mseq_pkg::IDLE;
        else        state_q <= state_d;
    end

    // Next state and word-generate decision; a load strobe always wins.
    always_comb begin
        state_d = state_q;
        gen     = 1'b0;
        case (state_q)
            mseq_pkg::IDLE: if (load) state_d = mseq_pkg::LOAD;
            mseq_pkg::LOAD: state_d = load ? mseq_pkg::LOAD : mseq_pkg::RUN;
            mseq_pkg::RUN: begin
                if (load) state_d = mseq_pkg::LOAD;
                else      gen     = !dout_valid_q || out_if.dout_ready;
            end
            default: state_d = mseq_pkg::IDLE;
        endcase
    end

    // LFSR, output word register and seed bookkeeping; a load drops any pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            seeded       <= 1'b0;
            reseed_cnt   <= '0;
        end else if (load) begin
            lfsr_q       <= fold_val;
            dout_valid_q <= 1'b0;
            seeded       <= 1'b1;
            reseed_cnt   <= reseed_cnt + 16'd1;
        end else if (gen) begin
            lfsr_q       <= lfsr_adv;
            dout_q       <= word;
            dout_valid_q <= 1'b1;
        end
    end

`ifdef MSEQ_STATS_EN
    // Accepted-word counter, saturating, restarted by each new seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       word_cnt <= '0;
        else if (load)                    word_cnt <= '0;
        else if (accept && word_cnt != '1) word_cnt <= word_cnt + 32'd1;
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_mseq_lfsr_gen.sv
// Bench for mseq_lfsr_gen (MSEQ_IDX=0, OUT_W=8): directed cases plus random strobes/ready.
// A transaction-level model predicts valid, word, seeded and counters every cycle.
// Inputs change on the falling edge; outputs are compared on the next falling edge.
module tb_mseq_lfsr_gen;

    localparam int OUT_W = 8;

    logic         clk;
    logic         rst_n;
    logic [287:0] din;
    logic [3:0]   dv;
    logic         seeded;
    logic [15:0]  rcnt;
`ifdef MSEQ_STATS_EN
    logic [31:0]  wcnt;
`endif

    mseq_lfsr_gen_if #(.OUT_W(OUT_W)) bus ();

    mseq_lfsr_gen #(.SEED_W(288), .MSEQ_IDX(0), .OUT_W(OUT_W), .ZERO_SUB(32'h0000_0001)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mseq_din       (din),
        .mseq_din_valid (dv),
        .out_if         (bus.master),
        .seeded         (seeded),
        .reseed_cnt     (rcnt)
`ifdef MSEQ_STATS_EN
        ,
        .word_cnt       (wcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fold(input logic [287:0] d);
        logic [31:0] f;
        f = 32'h0;
        for (int k = 0; k < 9; k++) f = f ^ 32'(d >> (32 * k));
        return (f == 32'h0) ? 32'h1 : f;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [7:0] next_word(input logic [31:0] s0);
        logic [31:0] s;
        logic [7:0]  w;
        s = s0;
        w = 8'h0;
        for (int i = 0; i < OUT_W; i++) begin
            w = {w[6:0], s[31]};
            s = lfsr_step(s);
        end
        return w;
    endfunction

    function automatic logic [31:0] next_state(input logic [31:0] s0);
        logic [31:0] s;
        s = s0;
        for (int i = 0; i < OUT_W; i++) s = lfsr_step(s);
        return s;
    endfunction

    int          m_phase;   // 0: no seed yet, 1: seed just loaded, 2: streaming
    logic        m_valid;
    logic [7:0]  m_word;
    logic [31:0] m_s;
    logic        m_seeded;
    logic [15:0] m_rcnt;
    logic [31:0] m_wcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_valid  <= 1'b0;
            m_word   <= 8'h0;
            m_s      <= 32'h0;
            m_seeded <= 1'b0;
            m_rcnt   <= 16'h0;
            m_wcnt   <= 32'h0;
        end else if (dv[0]) begin
            m_s      <= ref_fold(din);
            m_valid  <= 1'b0;
            m_phase  <= 1;
            m_seeded <= 1'b1;
            m_rcnt   <= m_rcnt + 16'h1;
            m_wcnt   <= 32'h0;
        end else begin
            if (m_valid && bus.dout_ready && m_wcnt != 32'hFFFF_FFFF) m_wcnt <= m_wcnt + 32'h1;
            if (m_phase == 1) m_phase <= 2;
            else if (m_phase == 2 && (!m_valid || bus.dout_ready)) begin
                m_word  <= next_word(m_s);
                m_s     <= next_state(m_s);
                m_valid <= 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
        if (m_valid) chk("dout", 32'(bus.dout), 32'(m_word));
        chk("seeded", 32'(seeded), 32'(m_seeded));
        chk("reseed_cnt", 32'(rcnt), 32'(m_rcnt));
`ifdef MSEQ_STATS_EN
        chk("word_cnt", wcnt, m_wcnt);
`endif
        if (m_seeded) begin
            n_cmp++;
            if (dut.lfsr_q == 32'h0) begin
                n_err++;
                $display("FAIL lfsr_nonzero: got 0, expected nonzero at %0t", $time);
            end
        end
    endtask

    task automatic cyc(input logic [3:0] st, input logic rdy);
        dv             = st;
        bus.dout_ready = rdy;
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic set_chunk0(input logic [31:0] c0);
        din         = '0;
        din[31:0]   = c0;
    endtask

    logic [7:0]  hold_w;
    logic [31:0] hold_s;
    logic [15:0] hold_c;

    initial begin
        rst_n          = 1'b0;
        din            = '0;
        dv             = 4'b0;
        bus.dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        compare_cycle();
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_seeded", 32'(seeded), 32'h0);
        rst_n = 1'b1;
        cyc(4'b0, 1'b1);
        cyc(4'b0001 & 4'b0, 1'b1);   // nothing loaded yet: still idle
        chk("idle_valid", 32'(bus.dout_valid), 32'h0);

        // Seed chunk0 = 8000_0000: first word 8'h80 after edge T+2.
        set_chunk0(32'h8000_0000);
        cyc(4'b0001, 1'b1);
        chk("t1_seeded", 32'(seeded), 32'h1);
        chk("t1_reseed_cnt", 32'(rcnt), 32'h1);
        chk("t1_valid_T", 32'(bus.dout_valid), 32'h0);
        cyc(4'b0, 1'b1);
        chk("t1_valid_T1", 32'(bus.dout_valid), 32'h0);
        cyc(4'b0, 1'b1);
        chk("t1_valid_T2", 32'(bus.dout_valid), 32'h1);
        chk("t1_first_word", 32'(bus.dout), 32'h80);
        repeat (5) cyc(4'b0, 1'b1);

        // All-ones fold: first word is the top byte, 8'hFF.
        set_chunk0(32'hFFFF_FFFF);
        cyc(4'b0001, 1'b1);
        cyc(4'b0, 1'b1);
        cyc(4'b0, 1'b1);
        chk("ones_first_word", 32'(bus.dout), 32'hFF);

        // Two equal chunks cancel: zero fold, ZERO_SUB=1 loaded, word 0, state 0x1B6 after it.
        set_chunk0(32'hDEAD_BEEF);
        din[63:32] = 32'hDEAD_BEEF;
        cyc(4'b0001, 1'b1);
        cyc(4'b0, 1'b1);
        cyc(4'b0, 1'b1);
        chk("zero_first_word", 32'(bus.dout), 32'h00);
        chk("zero_model_state", m_s, 32'h0000_01B6);
        chk("zero_dut_state", dut.lfsr_q, 32'h0000_01B6);
        repeat (1000) cyc(4'b0, 1'b1);

        // Stall right after the first word of a new seed.
        set_chunk0(32'h1234_5678);
        cyc(4'b0001, 1'b1);
        cyc(4'b0, 1'b1);
        cyc(4'b0, 1'b0);
        hold_w = bus.dout;
        hold_s = dut.lfsr_q;
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0, 1'b0);
            chk("stall_dout", 32'(bus.dout), 32'(hold_w));
            chk("stall_lfsr", dut.lfsr_q, hold_s);
        end
        cyc(4'b0, 1'b1);   // accepts word 0, model supplies word 1

        // Foreign strobe ignored, then reseed over a pending word.
        cyc(4'b0, 1'b0);
        hold_w = bus.dout;
        hold_c = rcnt;
        cyc(4'b0010, 1'b0);
        chk("foreign_cnt", 32'(rcnt), 32'(hold_c));
        chk("foreign_dout", 32'(bus.dout), 32'(hold_w));
        set_chunk0(32'h0F0F_0F0F);
        cyc(4'b0001, 1'b0);
        chk("reseed_valid0", 32'(bus.dout_valid), 32'h0);
`ifdef MSEQ_STATS_EN
        chk("reseed_word_cnt", wcnt, 32'h0);
`endif
        cyc(4'b0, 1'b1);
        chk("reseed_valid1", 32'(bus.dout_valid), 32'h0);
        cyc(4'b0, 1'b1);
        chk("reseed_first", 32'(bus.dout), 32'(next_word(32'h0F0F_0F0F)));

        // Random strobes, seeds and backpressure.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] st;
            st = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            if (st != 4'b0) begin
                for (int k = 0; k < 9; k++) din[32*k +: 32] = $urandom;
                if ($urandom_range(0, 7) == 0) din = '0;
            end
            cyc(st, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset in the middle of a stream.
        set_chunk0(32'hCAFE_F00D);
        cyc(4'b0001, 1'b1);
        repeat (4) cyc(4'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dout", 32'(bus.dout), 32'h0);
        chk("arst_valid", 32'(bus.dout_valid), 32'h0);
        chk("arst_seeded", 32'(seeded), 32'h0);
        chk("arst_reseed_cnt", 32'(rcnt), 32'h0);
`ifdef MSEQ_STATS_EN
        chk("arst_word_cnt", wcnt, 32'h0);
`endif
        @(negedge clk);
        compare_cycle();
        rst_n = 1'b1;
        repeat (3) cyc(4'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
